// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the receive frame FIFO.
package eth_rx_pkg;

   localparam int FCS_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DROP = 2'd2
   } rx_state_e;

   // One frame-store entry: payload byte plus end-of-frame marker.
   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } rx_entry_t;

endpackage

// File: rtl/axis_rx_frame_fifo_if.sv
// Byte-wide AXI-stream bundle used on both sides of the receive frame FIFO.
interface axis_rx_frame_fifo_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tlast;
   logic       tuser;
   logic       tready;

   modport master (output tdata, tvalid, tlast, tuser, input  tready);
   modport slave  (input  tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_rx_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// Contents are deliberately not reset.
module axis_rx_ram
   import eth_rx_pkg::*;
#(
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  rx_entry_t             wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output rx_entry_t             rd_data
);

   rx_entry_t mem [2**ADDR_WIDTH];

   // Write and registered read; rd_data holds while rd_en is low.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/axis_rx_frame_fifo.sv
// Receive frame FIFO. Frames are written speculatively at wr_cur and only
// published to the read side (wr_commit) once their last beat arrives clean;
// bad, overflowing or runt frames are rolled back.
// Optional build macro RX_FCS_STRIP_EN: strip the trailing 4-byte FCS and
// drop frames of 4 beats or fewer as runts.
//
// state | meaning
// IDLE  | between frames, next beat starts a frame
// RECV  | mid-frame, beats are being stored
// DROP  | store filled mid-frame, discarding until tlast
module axis_rx_frame_fifo
   import eth_rx_pkg::*;
#(
   parameter int ADDR_WIDTH = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   axis_rx_frame_fifo_if.slave  input_axis,
   axis_rx_frame_fifo_if.master output_axis,
   output logic                 frame_good,
   output logic                 frame_bad,
   output logic                 frame_overflow,
   output logic                 frame_runt,
   output logic [31:0]          good_count,
   output logic [31:0]          drop_count
);

   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

   rx_state_e             state;
   logic [ADDR_WIDTH-1:0] wr_cur;
   logic [ADDR_WIDTH-1:0] wr_commit;
   logic [ADDR_WIDTH-1:0] rd_ptr;

   logic      beat;
   logic      end_bad;
   logic      runt_end;
   logic      full;
   logic      wr_try;
   logic      wr_en;
   rx_entry_t wr_entry;
   rx_entry_t rd_entry;

   logic       rd_issue;
   logic       ram_vld;
   logic       move;
   logic       out_vld;
   logic       out_last;
   logic [7:0] out_data;

   // The receive side has no back-pressure.
   assign input_axis.tready = 1'b1;

   assign beat    = input_axis.tvalid;
   assign end_bad = beat && input_axis.tlast && input_axis.tuser && (state != DROP);
   // One slot always stays empty so full and empty are distinguishable.
   assign full    = ((wr_cur + PTR_ONE) == rd_ptr);
   assign wr_en   = wr_try && !full;

`ifdef RX_FCS_STRIP_EN
   logic [7:0] dly [FCS_BYTES];
   logic [2:0] dly_cnt;
   logic       dly_full;

   assign dly_full = (dly_cnt == 3'(FCS_BYTES));
   // A byte leaves the delay line only once FCS_BYTES newer bytes exist, so
   // the last FCS_BYTES of each frame never reach the store.
   assign wr_try   = beat && (state != DROP) && !end_bad && dly_full;
   assign wr_entry = '{last: input_axis.tlast, data: dly[FCS_BYTES-1]};
   assign runt_end = beat && input_axis.tlast && !input_axis.tuser
                     && (state != DROP) && !dly_full;

   // FCS delay line; emptied at every frame end (commit or rollback).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dly_cnt <= '0;
         for (int i = 0; i < FCS_BYTES; i++) dly[i] <= '0;
      end else if (beat) begin
         if (input_axis.tlast) begin
            dly_cnt <= '0;
         end else begin
            dly[0] <= input_axis.tdata;
            for (int i = 1; i < FCS_BYTES; i++) dly[i] <= dly[i-1];
            if (!dly_full) dly_cnt <= dly_cnt + 3'd1;
         end
      end
   end
`else
   assign wr_try   = beat && (state != DROP) && !end_bad;
   assign wr_entry = '{last: input_axis.tlast, data: input_axis.tdata};
   assign runt_end = 1'b0;
`endif

   // Input frame state machine: store, then commit or roll back at frame end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         wr_cur         <= '0;
         wr_commit      <= '0;
         frame_good     <= 1'b0;
         frame_bad      <= 1'b0;
         frame_overflow <= 1'b0;
         frame_runt     <= 1'b0;
         good_count     <= '0;
         drop_count     <= '0;
      end else begin
         frame_good     <= 1'b0;
         frame_bad      <= 1'b0;
         frame_overflow <= 1'b0;
         frame_runt     <= 1'b0;
         if (wr_en) wr_cur <= wr_cur + PTR_ONE;
         if (beat) begin
            if (state == DROP) begin
               if (input_axis.tlast) begin
                  wr_cur         <= wr_commit;
                  frame_overflow <= 1'b1;
                  drop_count     <= drop_count + 32'd1;
                  state          <= IDLE;
               end
            end else if (input_axis.tlast) begin
               state <= IDLE;
               if (end_bad) begin
                  wr_cur     <= wr_commit;
                  frame_bad  <= 1'b1;
                  drop_count <= drop_count + 32'd1;
               end else if (runt_end) begin
                  wr_cur     <= wr_commit;
                  frame_runt <= 1'b1;
                  drop_count <= drop_count + 32'd1;
               end else if (full) begin
                  wr_cur         <= wr_commit;
                  frame_overflow <= 1'b1;
                  drop_count     <= drop_count + 32'd1;
               end else begin
                  wr_commit  <= wr_cur + PTR_ONE;
                  frame_good <= 1'b1;
                  good_count <= good_count + 32'd1;
               end
            end else if (wr_try && full) begin
               state <= DROP;
            end else begin
               state <= RECV;
            end
         end
      end
   end

   // The RAM output register is a pipeline stage: refill it whenever it is
   // empty or its entry moves into the output register this cycle.
   assign move     = ram_vld && (!out_vld || output_axis.tready);
   assign rd_issue = (rd_ptr != wr_commit) && (!ram_vld || move);

   // Read pipeline: RAM read stage feeding the output register under back-pressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         ram_vld  <= 1'b0;
         out_vld  <= 1'b0;
         out_data <= '0;
         out_last <= 1'b0;
      end else begin
         if (rd_issue) rd_ptr <= rd_ptr + PTR_ONE;
         if (rd_issue)  ram_vld <= 1'b1;
         else if (move) ram_vld <= 1'b0;
         if (move) begin
            out_vld  <= 1'b1;
            out_data <= rd_entry.data;
            out_last <= rd_entry.last;
         end else if (output_axis.tready) begin
            out_vld <= 1'b0;
         end
      end
   end

   assign output_axis.tvalid = out_vld;
   assign output_axis.tdata  = out_data;
   assign output_axis.tlast  = out_last;
   assign output_axis.tuser  = 1'b0;

   axis_rx_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_cur),
      .wr_data (wr_entry),
      .rd_en   (rd_issue),
      .rd_addr (rd_ptr),
      .rd_data (rd_entry)
   );

endmodule
